// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register indices, field positions, ExcCodes and FSM states.
package cp0_pkg;

    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;

    localparam int IE_BIT   = 0;
    localparam int EXL_BIT  = 1;
    localparam int IRQ_BASE = 8;
    localparam int EXC_LSB  = 2;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_OV   = 5'd12;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_VECTOR = 2'd1,
        ST_RETURN = 2'd2
    } cp0_state_t;

endpackage

// File: rtl/cp0_exc_ctrl_if.sv
// Control-unit <-> CP0 signal bundle; master is the control unit, slave is CP0.
interface cp0_exc_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int N_IRQ  = 6
);
    logic [DATA_W-1:0] pc_i;
    logic              exc_req_i;
    logic [4:0]        exc_code_i;
    logic [N_IRQ-1:0]  irq_i;
    logic              eret_i;
    logic              mtc0_i;
    logic [4:0]        cp0_addr_i;
    logic [DATA_W-1:0] wdata_i;
    logic [DATA_W-1:0] rdata_o;
    logic [DATA_W-1:0] epc_o;
    logic [DATA_W-1:0] status_o;
    logic [DATA_W-1:0] cause_o;
    logic              redirect_o;
    logic [DATA_W-1:0] redirect_pc_o;
    logic              busy_o;

    modport master (
        output pc_i, exc_req_i, exc_code_i, irq_i, eret_i, mtc0_i, cp0_addr_i, wdata_i,
        input  rdata_o, epc_o, status_o, cause_o, redirect_o, redirect_pc_o, busy_o
    );

    modport slave (
        input  pc_i, exc_req_i, exc_code_i, irq_i, eret_i, mtc0_i, cp0_addr_i, wdata_i,
        output rdata_o, epc_o, status_o, cause_o, redirect_o, redirect_pc_o, busy_o
    );
endinterface

// File: rtl/cp0_irq_pending.sv
// Samples the interrupt lines into IP every cycle and reduces them against IM/IE/EXL.
module cp0_irq_pending #(
    parameter int N_IRQ = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IRQ-1:0] irq,
    input  logic             ie,
    input  logic             exl,
    input  logic [N_IRQ-1:0] im,
    output logic [N_IRQ-1:0] ip,
    output logic             pending
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            ip <= '0;
        end else begin
            ip <= irq;
        end
    end

    assign pending = ie && !exl && (|(ip & im));

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception controller: Status/Cause/EPC storage, mtc0/mfc0 access, and the
// IDLE/VECTOR/RETURN sequencer that stalls the control unit and redirects the PC.
module cp0_exc_ctrl
    import cp0_pkg::*;
#(
    parameter int          DATA_W     = 32,
    parameter int          N_IRQ      = 6,
    parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
    input logic         Clk,
    input logic         Reset,
    cp0_exc_ctrl_if.slave bus
);

    localparam logic [DATA_W-1:0] VEC = DATA_W'(EXC_VECTOR);
    localparam logic [DATA_W-1:0] STATUS_MASK =
        {{(DATA_W-IRQ_BASE-N_IRQ){1'b0}}, {N_IRQ{1'b1}}, 6'b0, 2'b11};

    cp0_state_t        state;
    logic [DATA_W-1:0] status_q;
    logic [DATA_W-1:0] epc_q;
    logic [4:0]        exc_code_q;
    logic              redirect_q;
    logic              busy_q;
    logic              ret_sel_q;

    logic              ie;
    logic              exl;
    logic [N_IRQ-1:0]  im;
    logic [N_IRQ-1:0]  ip;
    logic              pending;
    logic [DATA_W-1:0] cause;

    assign ie  = status_q[IE_BIT];
    assign exl = status_q[EXL_BIT];
    assign im  = status_q[IRQ_BASE +: N_IRQ];

    cp0_irq_pending #(.N_IRQ(N_IRQ)) u_irq_pending (
        .clk     (Clk),
        .reset   (Reset),
        .irq     (bus.irq_i),
        .ie      (ie),
        .exl     (exl),
        .im      (im),
        .ip      (ip),
        .pending (pending)
    );

    always_comb begin
        cause = '0;
        cause[EXC_LSB +: 5]    = exc_code_q;
        cause[IRQ_BASE +: N_IRQ] = ip;
    end

    // Redirect/busy are registered alongside the state so they are glitch-free;
    // redirect_q is high exactly while the FSM sits in VECTOR or RETURN.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state      <= ST_IDLE;
            status_q   <= '0;
            epc_q      <= '0;
            exc_code_q <= '0;
            redirect_q <= 1'b0;
            busy_q     <= 1'b0;
            ret_sel_q  <= 1'b0;
        end else begin
            redirect_q <= 1'b0;
            busy_q     <= 1'b0;
            ret_sel_q  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.exc_req_i || pending) begin
                        // A nested exception keeps the original return address.
                        if (!exl) epc_q <= bus.pc_i;
                        exc_code_q        <= bus.exc_req_i ? bus.exc_code_i : EXC_INT;
                        status_q[EXL_BIT] <= 1'b1;
                        state             <= ST_VECTOR;
                        redirect_q        <= 1'b1;
                        busy_q            <= 1'b1;
                    end else if (bus.eret_i) begin
                        status_q[EXL_BIT] <= 1'b0;
                        state             <= ST_RETURN;
                        redirect_q        <= 1'b1;
                        busy_q            <= 1'b1;
                        ret_sel_q         <= 1'b1;
                    end else if (bus.mtc0_i) begin
                        if (bus.cp0_addr_i == CP0_STATUS) begin
                            status_q <= bus.wdata_i & STATUS_MASK;
                        end else if (bus.cp0_addr_i == CP0_EPC) begin
                            epc_q <= bus.wdata_i;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        case (bus.cp0_addr_i)
            CP0_STATUS: bus.rdata_o = status_q;
            CP0_CAUSE:  bus.rdata_o = cause;
            CP0_EPC:    bus.rdata_o = epc_q;
            default:    bus.rdata_o = '0;
        endcase
    end

    assign bus.epc_o         = epc_q;
    assign bus.status_o      = status_q;
    assign bus.cause_o       = cause;
    assign bus.redirect_o    = redirect_q;
    assign bus.busy_o        = busy_q;
    assign bus.redirect_pc_o = ret_sel_q ? epc_q : VEC;

endmodule
